// File: rtl/residual_runlevel_scanner.sv
// Zigzag run/level scanner for a 4x4 block of signed 8-bit quantised coefficients.
// Emits one (run, level) beat per non-zero, flags the last one, and emits a single beat for empty blocks.
module residual_runlevel_scanner (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] coeff_in [16],
    input  logic [31:0]       mbnumber_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_run,
    output logic signed [7:0] out_level,
    output logic              out_last,
    output logic              out_empty,
    output logic [4:0]        out_total,
    output logic [31:0]       out_mbnumber
);

    typedef enum logic {StIdle, StScan} state_e;

    function automatic logic [3:0] zz_raster(input logic [3:0] p);
        logic [3:0] r;
        unique case (p)
            4'd0:  r = 4'd0;
            4'd1:  r = 4'd1;
            4'd2:  r = 4'd4;
            4'd3:  r = 4'd8;
            4'd4:  r = 4'd5;
            4'd5:  r = 4'd2;
            4'd6:  r = 4'd3;
            4'd7:  r = 4'd6;
            4'd8:  r = 4'd9;
            4'd9:  r = 4'd12;
            4'd10: r = 4'd13;
            4'd11: r = 4'd10;
            4'd12: r = 4'd7;
            4'd13: r = 4'd11;
            4'd14: r = 4'd14;
            default: r = 4'd15;
        endcase
        return r;
    endfunction

    state_e            state_q, state_d;
    logic signed [7:0] coeff_q [16];
    logic signed [7:0] coeff_d [16];
    logic [31:0]       tag_q, tag_d;
    logic [3:0]        pos_q, pos_d;
    logic [3:0]        run_q, run_d;
    logic [3:0]        lastpos_q, lastpos_d;
    logic              empty_q, empty_d;
    logic [4:0]        total_q, total_d;

    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_run_q, out_run_d;
    logic signed [7:0] out_level_q, out_level_d;
    logic              out_last_q, out_last_d;
    logic              out_empty_q, out_empty_d;
    logic [4:0]        out_total_q, out_total_d;
    logic [31:0]       out_mbnumber_q, out_mbnumber_d;

    logic [4:0]        in_nz;
    logic [3:0]        in_lastpos;
    logic              adv;
    logic signed [7:0] cur;

    // Block summary computed on the incoming coefficients so it is ready at accept time.
    always_comb begin
        in_nz      = 5'd0;
        in_lastpos = 4'd0;
        for (int p = 0; p < 16; p++) begin
            if (coeff_in[zz_raster(4'(p))] != 8'sd0) begin
                in_nz      = in_nz + 5'd1;
                in_lastpos = 4'(p);
            end
        end
    end

    assign adv      = !out_valid_q || out_ready;
    assign cur      = coeff_q[zz_raster(pos_q)];
    assign in_ready = (state_q == StIdle) && !reset;

    always_comb begin
        state_d        = state_q;
        coeff_d        = coeff_q;
        tag_d          = tag_q;
        pos_d          = pos_q;
        run_d          = run_q;
        lastpos_d      = lastpos_q;
        empty_d        = empty_q;
        total_d        = total_q;
        out_valid_d    = out_valid_q;
        out_run_d      = out_run_q;
        out_level_d    = out_level_q;
        out_last_d     = out_last_q;
        out_empty_d    = out_empty_q;
        out_total_d    = out_total_q;
        out_mbnumber_d = out_mbnumber_q;

        unique case (state_q)
            StIdle: begin
                // A pending final beat from the previous block may still be waiting here.
                if (adv) begin
                    out_valid_d = 1'b0;
                end
                if (in_valid) begin
                    coeff_d   = coeff_in;
                    tag_d     = mbnumber_in;
                    total_d   = in_nz;
                    lastpos_d = in_lastpos;
                    empty_d   = (in_nz == 5'd0);
                    pos_d     = 4'd0;
                    run_d     = 4'd0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (adv) begin
                    if (cur != 8'sd0 || empty_q) begin
                        out_valid_d    = 1'b1;
                        out_run_d      = run_q;
                        out_level_d    = cur;
                        out_last_d     = (pos_q == lastpos_q);
                        out_empty_d    = empty_q;
                        out_total_d    = total_q;
                        out_mbnumber_d = tag_q;
                        run_d          = 4'd0;
                    end else begin
                        out_valid_d = 1'b0;
                        run_d       = run_q + 4'd1;
                    end
                    if (pos_q == lastpos_q) begin
                        state_d = StIdle;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            tag_q          <= 32'd0;
            pos_q          <= 4'd0;
            run_q          <= 4'd0;
            lastpos_q      <= 4'd0;
            empty_q        <= 1'b0;
            total_q        <= 5'd0;
            out_valid_q    <= 1'b0;
            out_run_q      <= 4'd0;
            out_level_q    <= 8'sd0;
            out_last_q     <= 1'b0;
            out_empty_q    <= 1'b0;
            out_total_q    <= 5'd0;
            out_mbnumber_q <= 32'd0;
            for (int i = 0; i < 16; i++) begin
                coeff_q[i] <= 8'sd0;
            end
        end else begin
            state_q        <= state_d;
            tag_q          <= tag_d;
            pos_q          <= pos_d;
            run_q          <= run_d;
            lastpos_q      <= lastpos_d;
            empty_q        <= empty_d;
            total_q        <= total_d;
            out_valid_q    <= out_valid_d;
            out_run_q      <= out_run_d;
            out_level_q    <= out_level_d;
            out_last_q     <= out_last_d;
            out_empty_q    <= out_empty_d;
            out_total_q    <= out_total_d;
            out_mbnumber_q <= out_mbnumber_d;
            for (int i = 0; i < 16; i++) begin
                coeff_q[i] <= coeff_d[i];
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_run      = out_run_q;
    assign out_level    = out_level_q;
    assign out_last     = out_last_q;
    assign out_empty    = out_empty_q;
    assign out_total    = out_total_q;
    assign out_mbnumber = out_mbnumber_q;

endmodule

// File: tb/tb_residual_runlevel_scanner.sv
// Randomised and directed bench for residual_runlevel_scanner against a zigzag run/level model.
module tb_residual_runlevel_scanner;

    typedef logic signed [7:0] blk_t [16];
    typedef struct packed {
        logic [3:0]        run;
        logic signed [7:0] level;
        logic              last;
        logic              empty;
        logic [4:0]        total;
        logic [31:0]       tag;
    } beat_t;

    localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] coeff_in [16];
    logic [31:0]       mbnumber_in;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_run;
    logic signed [7:0] out_level;
    logic              out_last;
    logic              out_empty;
    logic [4:0]        out_total;
    logic [31:0]       out_mbnumber;

    beat_t got[$];
    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    residual_runlevel_scanner dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .coeff_in     (coeff_in),
        .mbnumber_in  (mbnumber_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_run      (out_run),
        .out_level    (out_level),
        .out_last     (out_last),
        .out_empty    (out_empty),
        .out_total    (out_total),
        .out_mbnumber (out_mbnumber)
    );

    always @(posedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got.push_back({out_run, out_level, out_last, out_empty, out_total, out_mbnumber});
        end
    end

    function automatic blk_t zero_blk();
        blk_t b;
        foreach (b[i]) b[i] = 8'sd0;
        return b;
    endfunction

    // Expected beats: walk the zigzag list, count zeros between non-zeros, drop the tail.
    function automatic void model(input blk_t c, input logic [31:0] tag);
        int    nz   = 0;
        int    seen = 0;
        int    run  = 0;
        beat_t b;
        foreach (c[i]) if (c[i] != 0) nz++;
        if (nz == 0) begin
            b = {4'd0, 8'sd0, 1'b1, 1'b1, 5'd0, tag};
            exp_q.push_back(b);
        end else begin
            for (int p = 0; p < 16; p++) begin
                if (c[ZZ[p]] != 0) begin
                    seen++;
                    b = {4'(run), c[ZZ[p]], (seen == nz), 1'b0, 5'(nz), tag};
                    exp_q.push_back(b);
                    run = 0;
                end else begin
                    run++;
                end
            end
        end
    endfunction

    task automatic send_block(input blk_t c, input logic [31:0] tag, output bit ok);
        bit acc;
        ok          = 1'b0;
        in_valid    = 1'b1;
        coeff_in    = c;
        mbnumber_in = tag;
        for (int i = 0; i < 300; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_beats();
        for (int i = 0; i < 600 && got.size() < exp_q.size(); i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        coeff_in  = zero_blk();
        mbnumber_in = 32'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, out_run, out_level, out_last, out_empty, out_total, out_mbnumber} !== '0
                || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold got valid=%b ready=%b run=%0d level=%0d tag=%0d want all 0",
                         out_valid, in_ready, out_run, out_level, out_mbnumber);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_run, out_level, out_last, out_empty, out_total, out_mbnumber} !== '0
            || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_reset got valid=%b ready=%b want valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_single_dc();
        blk_t c = zero_blk();
        bit   ok;
        got.delete();
        exp_q.delete();
        c[0] = 8'sd5;
        model(c, 32'd7);
        send_block(c, 32'd7, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dc_accept got timeout want accept");
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_run !== 4'd0 || out_level !== 8'sd5 || out_last !== 1'b1
            || out_empty !== 1'b0 || out_total !== 5'd1 || out_mbnumber !== 32'd7
            || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL dc_beat got v=%b run=%0d lvl=%0d last=%b emp=%b tot=%0d tag=%0d rdy=%b want 1,0,5,1,0,1,7,1",
                     out_valid, out_run, out_level, out_last, out_empty, out_total, out_mbnumber,
                     in_ready);
        end
        wait_beats();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL dc_count got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL dc_stream beat %0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_sparse();
        blk_t c = zero_blk();
        bit   ok;
        got.delete();
        exp_q.delete();
        c[1]  = 8'sd3;
        c[8]  = -8'sd2;
        c[15] = -8'sd128;
        model(c, 32'h55);
        send_block(c, 32'h55, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sparse_accept got timeout want accept");
        end
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_level !== -8'sd128 || out_last !== 1'b1
            || out_run !== 4'd11) begin
            failures++;
            $display("FAIL sparse_last_latency got v=%b lvl=%0d last=%b run=%0d want 1,-128,1,11",
                     out_valid, out_level, out_last, out_run);
        end
        wait_beats();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL sparse_count got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL sparse_stream beat %0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_all_zero();
        bit ok;
        got.delete();
        exp_q.delete();
        model(zero_blk(), 32'hABCD);
        send_block(zero_blk(), 32'hABCD, ok);
        @(posedge clk);
        #1;
        checks++;
        if (!ok || out_valid !== 1'b1 || out_empty !== 1'b1 || out_last !== 1'b1
            || out_level !== 8'sd0 || out_run !== 4'd0 || out_total !== 5'd0) begin
            failures++;
            $display("FAIL empty_beat got ok=%b v=%b emp=%b last=%b lvl=%0d run=%0d tot=%0d want 1,1,1,1,0,0,0",
                     ok, out_valid, out_empty, out_last, out_level, out_run, out_total);
        end
        wait_beats();
        checks++;
        if (got.size() !== 1 || got[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL empty_stream got %0d beats first %h want 1 beat %h",
                     got.size(), (got.size() > 0) ? got[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_backpressure();
        blk_t c = zero_blk();
        bit   ok;
        int   bad = 0;
        got.delete();
        exp_q.delete();
        c[0] = 8'sd1;
        c[1] = 8'sd2;
        model(c, 32'd9);
        out_ready = 1'b0;
        send_block(c, 32'd9, ok);
        @(posedge clk);
        #1;
        checks++;
        if (!ok || out_valid !== 1'b1 || out_level !== 8'sd1 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL bp_first got ok=%b v=%b lvl=%0d last=%b want 1,1,1,0",
                     ok, out_valid, out_level, out_last);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_level !== 8'sd1 || out_run !== 4'd0
                || out_last !== 1'b0 || out_total !== 5'd2 || out_mbnumber !== 32'd9
                || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_stall_stable got %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_level !== 8'sd2 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL bp_second got v=%b lvl=%0d last=%b want 1,2,1",
                     out_valid, out_level, out_last);
        end
        wait_beats();
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL bp_count got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_stream beat %0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        blk_t a = zero_blk();
        blk_t b = zero_blk();
        bit   ok1, ok2;
        got.delete();
        exp_q.delete();
        a[0] = 8'sd4;
        a[2] = -8'sd7;
        a[6] = 8'sd127;
        b[0] = -8'sd1;
        b[4] = 8'sd2;
        b[9] = 8'sd3;
        model(a, 32'd1);
        model(b, 32'd2);
        out_ready = 1'b1;
        send_block(a, 32'd1, ok1);
        send_block(b, 32'd2, ok2);
        wait_beats();
        checks++;
        if (!ok1 || !ok2 || got.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got ok=%b%b beats=%0d want 11 beats=%0d",
                     ok1, ok2, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_stream beat %0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        blk_t a = zero_blk();
        blk_t b = zero_blk();
        bit   ok1, ok2;
        int   bad = 0;
        int   tag2 = 0;
        got.delete();
        exp_q.delete();
        a[0]  = 8'sd10;
        a[5]  = 8'sd11;
        b[14] = 8'sd9;
        b[15] = -8'sd3;
        model(a, 32'd1);
        out_ready = 1'b1;
        send_block(a, 32'd1, ok1);
        send_block(b, 32'd2, ok2);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (!ok1 || !ok2 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_valid got ok=%b%b v=%b want 11 v=0", ok1, ok2, out_valid);
        end
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        foreach (got[i]) if (got[i].tag == 32'd2) tag2++;
        checks++;
        if (bad != 0 || tag2 != 0) begin
            failures++;
            $display("FAIL rst_mid_silence got valid_cycles=%0d tag2_beats=%0d want 0 0", bad, tag2);
        end
        checks++;
        if (got.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL rst_mid_count got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rst_mid_stream beat %0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok_all = 1'b1;
        bit done   = 1'b0;
        got.delete();
        exp_q.delete();
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    blk_t c;
                    bit   ok;
                    int   dens = $urandom_range(0, 4);
                    logic [31:0] tag = $urandom;
                    foreach (c[i]) c[i] = ($urandom_range(0, 3) < dens) ? 8'($urandom) : 8'sd0;
                    model(c, tag);
                    send_block(c, tag, ok);
                    if (!ok) ok_all = 1'b0;
                end
                done = 1'b1;
            end
            begin
                for (int k = 0; k < 8000 && !done; k++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_beats();
        checks++;
        if (!ok_all || got.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got ok=%b beats=%0d want 1 beats=%0d",
                     ok_all, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_stream beat %0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_dc();
        test_sparse();
        test_all_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/residual_runlevel_scanner.md
# residual_runlevel_scanner

Downstream consumer of the transform coder's processed 4x4 luma residual block. It accepts one block of 16 signed 8-bit quantised coefficients in raster order and walks them in 4x4 zigzag order. It emits one (run, level) beat per non-zero coefficient over a valid/ready stream, ready for the entropy coder. Trailing zeros are dropped, the last non-zero is flagged, and an all-zero block produces a single "empty" beat.

## Interface
- No parameters; block size fixed at 4x4, coefficient width 8.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  coefficient block and tag present
- in_ready  out  1  block accepted on edge where in_valid && in_ready
- coeff_in  in  signed [7:0] x [15:0] (unpacked)  raster order; index = row*4+col
- mbnumber_in  in  32  block tag, passed through
- out_valid  out  1  beat present
- out_ready  in  1  beat consumed on edge where out_valid && out_ready
- out_run  out  4  zeros preceding this level in zigzag order, since the previous non-zero
- out_level  out  signed 8  coefficient value, unmodified (-128 legal)
- out_last  out  1  final beat of block
- out_empty  out  1  block was all zero (only with out_last=1, level=0, run=0)
- out_total  out  5  count of non-zeros in block (0..16); constant over the block
- out_mbnumber  out  32  tag of block owning the beat

## Operation
- Zigzag position p -> raster index: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- States: IDLE, SCAN.
- in_ready = (state==IDLE) && !reset.
- Accept (IDLE, in_valid):
  - latch coeff_in and mbnumber_in
  - compute nz_count and lastpos, the highest zigzag position holding a non-zero
  - empty = (nz_count==0); lastpos=0 when empty
  - pos<=0, run<=0; go to SCAN
- SCAN advance condition adv = !out_valid || out_ready. When !adv, everything holds (pos, run, outputs).
- On each edge in SCAN with adv, let c = coeff[zz[pos]]:
  - c!=0 or empty:
    - load outputs: run, level=c, last=(pos==lastpos), empty flag, total, tag
    - out_valid<=1, run<=0
  - c==0 and not empty: run<=run+1; out_valid<=0 (previous beat consumed).
  - pos==lastpos: state<=IDLE; else pos<=pos+1.
- Positions after lastpos are never visited.
- Last-beat overlap: the final beat may still be pending while IDLE accepts the next block. The next block's first beat loads only when adv holds, so no beat is lost or overwritten.
- In IDLE with adv: out_valid<=0.
- run never exceeds 15; no saturation logic needed.

## Timing
- Reset: state=IDLE, out_valid=0, out_run=0, out_level=0, out_last=0, out_empty=0, out_total=0, out_mbnumber=0, pos=0, run=0.
- in_ready is low during the reset cycle and high the cycle after.
- Latency: block accepted at edge k, with out_ready=1 throughout:
  - non-zero at zigzag position p is visible after edge k+1+p
  - empty block's beat is visible after edge k+1
- Throughput: one zigzag position per cycle.
  - A block occupies lastpos+1 SCAN cycles plus the accept cycle.
  - in_ready rises the cycle after the edge that processes lastpos.
- Backpressure: while out_valid && !out_ready, all out_* hold stable and the scan stalls.
- Reset mid-scan: the block is discarded. out_valid=0 after the reset edge, and no further beats from that block.
- in_valid while in SCAN: ignored (in_ready=0); the upstream holds its data.

## Test plan
- Reset/idle: hold reset 3 cycles, then release -> out_valid=0 and all outputs 0 throughout; in_ready=1 on the first cycle after release.
- Single DC: coeff_in[0]=5, rest 0, mbnumber_in=7 -> one beat after edge k+1: run=0, level=5, last=1, empty=0, total=1, mbnumber=7; in_ready high next cycle.
- Sparse, trailing zero drop: coeff_in[1]=3, [8]=-2, [15]=-128, rest 0 -> beats (run0, 3), (run1, -2), (run11, -128, last=1); total=3 on all beats; third beat after edge k+16.
- All zero: block of zeros -> exactly one beat: run=0, level=0, last=1, empty=1, total=0.
- Backpressure: coeff_in[0]=1, [1]=2; hold out_ready=0 for 5 cycles after first out_valid -> beat (0,1) stays stable; second beat appears only after the handshake; in_ready=0 during the stall.
- Back-to-back and reset:
  - two blocks with tags 1 and 2, in_valid held, out_ready=1 -> all tag-1 beats precede tag-2 beats, none lost.
  - assert reset during the second block's scan -> out_valid=0 next cycle, no tag-2 beats afterwards.
